// File: rtl/mar_access_unit_if.sv
// Control/bus and RAM-side signal bundle for mar_access_unit.
// slave: the access unit; master: control unit plus RAM macro.
interface mar_access_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              mar_in;
  logic [ADDR_W-1:0] address;
  logic              mar_inc;
  logic              mar_dec;
  logic              acc_req;
  logic              acc_we;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_busy;
  logic              acc_done;
  logic              acc_fault;
  logic [DATA_W-1:0] acc_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_en;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  mar_in, address, mar_inc, mar_dec,
    input  acc_req, acc_we, acc_wdata, ram_rdata,
    output acc_busy, acc_done, acc_fault, acc_rdata,
    output ram_address, ram_en, ram_we, ram_wdata
  );

  modport master (
    output mar_in, address, mar_inc, mar_dec,
    output acc_req, acc_we, acc_wdata, ram_rdata,
    input  acc_busy, acc_done, acc_fault, acc_rdata,
    input  ram_address, ram_en, ram_we, ram_wdata
  );
endinterface

// File: rtl/mar_access_unit.sv
// Memory address register plus single-outstanding RAM access sequencer.
// Optional MAR_FAULT_EN: requests above MEM_TOP complete at once with a fault.
module mar_access_unit #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_TOP     = 255
) (
  input  logic            clk,
  input  logic            rst,
  mar_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] w_mar_nxt;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_fault;
  logic [3:0]        r_wcnt;
  logic              w_wait_last;
  logic              w_oob;
  logic              w_start;

`ifdef MAR_FAULT_EN
  assign w_oob = (int'(w_mar_nxt) > MEM_TOP);
`else
  logic w_unused_top;
  assign w_unused_top = (MEM_TOP > 0);
  assign w_oob = 1'b0;
`endif

  assign w_start     = (r_state == S_IDLE) && bus.acc_req;
  assign w_wait_last = (r_state == S_WAIT) && (r_wcnt == 4'd0);

  // MAR update: only in IDLE, load beats inc/dec, inc+dec cancel
  always_comb begin
    w_mar_nxt = r_mar;
    if (r_state == S_IDLE) begin
      if (bus.mar_in)
        w_mar_nxt = bus.address;
      else if (bus.mar_inc && !bus.mar_dec)
        w_mar_nxt = r_mar + ADDR_W'(1);
      else if (bus.mar_dec && !bus.mar_inc)
        w_mar_nxt = r_mar - ADDR_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.acc_req)
          w_state_nxt = w_oob ? S_DONE : S_ACCESS;
      end
      S_ACCESS: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_wcnt == 4'd0)
          w_state_nxt = S_DONE;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.acc_busy  = 1'b0;
    bus.acc_done  = 1'b0;
    bus.acc_fault = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    unique case (r_state)
      S_IDLE: ;
      S_ACCESS: begin
        bus.acc_busy = 1'b1;
        bus.ram_en   = 1'b1;
        bus.ram_we   = r_we;
      end
      S_WAIT: bus.acc_busy = 1'b1;
      S_DONE: begin
        bus.acc_busy  = 1'b1;
        bus.acc_done  = 1'b1;
        bus.acc_fault = r_fault;
      end
      default: ;
    endcase
  end

  // Datapath: MAR, request capture, wait counter, read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mar   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_fault <= 1'b0;
      r_wcnt  <= 4'd0;
    end else begin
      r_mar <= w_mar_nxt;
      if (w_start) begin
        r_we    <= bus.acc_we;
        r_wdata <= bus.acc_wdata;
        r_fault <= w_oob;
      end
      if (r_state == S_ACCESS)
        r_wcnt <= 4'(WAIT_CYCLES - 1);
      else if ((r_state == S_WAIT) && (r_wcnt != 4'd0))
        r_wcnt <= r_wcnt - 4'd1;
      if (w_wait_last && !r_we)
        r_rdata <= bus.ram_rdata;
    end
  end

  assign bus.ram_address = r_mar;
  assign bus.ram_wdata   = r_wdata;
  assign bus.acc_rdata   = r_rdata;

endmodule

// File: tb/tb_mar_access_unit.sv
// Directed bench for mar_access_unit with a behavioural synchronous RAM.
// Fault-path checks follow MAR_FAULT_EN.
module tb_mar_access_unit;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int WC  = 1;
  localparam int TOP = 127;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mar_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  mar_access_unit #(
    .ADDR_W(AW), .DATA_W(DW),
    .WAIT_CYCLES(WC), .MEM_TOP(TOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] ram_q = '0;
  assign bus.ram_rdata = ram_q;

  // Synchronous RAM macro model
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_address] <= bus.ram_wdata;
      else ram_q <= mem[bus.ram_address];
    end
  end

  int en_cnt = 0;
  int done_cnt = 0;
  // Pulse counters for enable and completion
  always @(posedge clk) begin
    if (bus.ram_en) en_cnt++;
    if (bus.acc_done) done_cnt++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int start, input string tag);
    int n;
    n = start;
    while (!bus.acc_done && n < 20) begin
      tick();
      n++;
    end
    chk(tag, n, 2 + WC);
  endtask

  task automatic run_acc(input logic we,
                         input logic [DW-1:0] wd,
                         input string tag);
    bus.acc_req   = 1'b1;
    bus.acc_we    = we;
    bus.acc_wdata = wd;
    tick();
    bus.acc_req = 1'b0;
    bus.acc_we  = 1'b0;
    wait_done(1, tag);
  endtask

  task automatic load(input logic [AW-1:0] a);
    bus.mar_in  = 1'b1;
    bus.address = a;
    tick();
    bus.mar_in = 1'b0;
  endtask

  initial begin
    int e0;
    int d0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e0;
    int d0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 16'hBEEF;
    mem[8'h80] = 16'hA5A5;
    rst = 1'b1;
    bus.mar_in = 1'b0;
    bus.address = '0;
    bus.mar_inc = 1'b0;
    bus.mar_dec = 1'b0;
    bus.acc_req = 1'b0;
    bus.acc_we = 1'b0;
    bus.acc_wdata = '0;
    tick();
    tick();
    chk("rst_addr", bus.ram_address, 0);
    chk("rst_busy", bus.acc_busy, 0);
    chk("rst_rdata", bus.acc_rdata, 0);
    chk("rst_en", bus.ram_en, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    rst = 1'b0;

    load(8'hFF);
    chk("ld_ff", bus.ram_address, 8'hFF);
    bus.mar_inc = 1'b1;
    tick();
    bus.mar_inc = 1'b0;
    chk("inc_wrap", bus.ram_address, 8'h00);
    bus.mar_inc = 1'b1;
    bus.mar_dec = 1'b1;
    tick();
    bus.mar_inc = 1'b0;
    bus.mar_dec = 1'b0;
    chk("incdec", bus.ram_address, 8'h00);
    bus.mar_dec = 1'b1;
    tick();
    bus.mar_dec = 1'b0;
    chk("dec_wrap", bus.ram_address, 8'hFF);
    bus.mar_inc = 1'b1;
    load(8'h42);
    bus.mar_inc = 1'b0;
    chk("ld_prio", bus.ram_address, 8'h42);

    e0 = en_cnt;
    bus.mar_in = 1'b1;
    bus.address = 8'h10;
    bus.acc_req = 1'b1;
    bus.acc_we = 1'b0;
    tick();
    bus.mar_in = 1'b0;
    bus.acc_req = 1'b0;
    chk("rd_en_t1", bus.ram_en, 1);
    chk("rd_we_t1", bus.ram_we, 0);
    chk("rd_addr", bus.ram_address, 8'h10);
    chk("rd_busy", bus.acc_busy, 1);
    tick();
    chk("rd_en_t2", bus.ram_en, 0);
    chk("rd_done_t2", bus.acc_done, 0);
    tick();
    chk("rd_done_t3", bus.acc_done, 1);
    chk("rd_fault", bus.acc_fault, 0);
    chk("rd_data", bus.acc_rdata, 16'hBEEF);
    bus.acc_req = 1'b1;
    tick();
    bus.acc_req = 1'b0;
    chk("done_req_ign", bus.acc_busy, 0);
    chk("done_pulse", bus.acc_done, 0);
    chk("rd_en_cnt", en_cnt - e0, 1);

    load(8'h20);
    bus.acc_req = 1'b1;
    bus.acc_we = 1'b1;
    bus.acc_wdata = 16'h1234;
    tick();
    bus.acc_req = 1'b0;
    bus.acc_we = 1'b0;
    chk("wr_we", bus.ram_we, 1);
    chk("wr_wdata", bus.ram_wdata, 16'h1234);
    bus.mar_in = 1'b1;
    bus.address = 8'h55;
    tick();
    bus.mar_in = 1'b0;
    chk("busy_ld_ign", bus.ram_address, 8'h20);
    wait_done(2, "wr_lat");
    chk("wr_keep_rd", bus.acc_rdata, 16'hBEEF);
    tick();
    chk("wr_mem", mem[8'h20], 16'h1234);
    run_acc(1'b0, '0, "rb_lat");
    chk("rb_data", bus.acc_rdata, 16'h1234);
    tick();

    d0 = done_cnt;
    load(8'h33);
    bus.acc_req = 1'b1;
    tick();
    bus.acc_req = 1'b0;
    tick();
    chk("abort_wait", bus.acc_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", bus.acc_busy, 0);
    chk("abort_en", bus.ram_en, 0);
    chk("abort_done", bus.acc_done, 0);
    chk("abort_mar", bus.ram_address, 0);
    chk("abort_rdata", bus.acc_rdata, 0);
    tick();
    tick();
    tick();
    chk("abort_nodone", done_cnt - d0, 0);

    load(8'h80);
    e0 = en_cnt;
    bus.acc_req = 1'b1;
    tick();
    bus.acc_req = 1'b0;
`ifdef MAR_FAULT_EN
    chk("flt_done", bus.acc_done, 1);
    chk("flt_fault", bus.acc_fault, 1);
    tick();
    chk("flt_idle", bus.acc_busy, 0);
    chk("flt_no_en", en_cnt - e0, 0);
    chk("flt_rdata", bus.acc_rdata, 0);
`else
    wait_done(1, "hi_lat");
    chk("hi_fault", bus.acc_fault, 0);
    chk("hi_data", bus.acc_rdata, 16'hA5A5);
    tick();
    chk("hi_en", en_cnt - e0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
